// File: rtl/mem_2ps_stream_reader.sv
// ---------------------------------------------------------------------------
// mem_2ps_stream_reader
//
// Purpose:
//   This is the read-side engine for a simple dual-port memory that has a
//   1-cycle registered read. It drains entries in order, from its own issue
//   pointer up to the writer's pointer, and presents them as a valid/ready
//   stream. It sustains full throughput and honours backpressure. It returns
//   its committed read pointer so that the writer can compute "full".
//
//   Entries are committed (freed) only when they are popped from the stream.
//   Up to two entries are outstanding at once, counting both those buffered
//   in the output FIFO and those in flight from the memory.
//
// Ports:
//   clk              clock, all logic on posedge
//   rst              synchronous active-high reset (overrides flush)
//   wr_ptr_i         writer pointer, MSB = wrap bit
//   rd_ptr_o         committed read pointer, MSB = wrap bit
//   flush_i          discard all unreturned entries, jump to wr_ptr_i
//   mem_addr_read_o  memory read address (issue pointer, combinational)
//   mem_data_read_i  memory read data, valid 1 cycle after the address
//   data_o           stream data (FIFO head register)
//   valid_o          stream valid (FIFO occupancy non-zero)
//   ready_i          stream ready
// ---------------------------------------------------------------------------
module mem_2ps_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_i,
  output logic [ADDR_WIDTH:0]   rd_ptr_o,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_read_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  logic [ADDR_WIDTH:0]   r_iss_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic       w_avail;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_level;
  logic       w_issue;
  logic       w_wr_tail;

  assign w_avail = (r_iss_ptr != wr_ptr_i);
  assign w_pop   = valid_o && ready_i;
  assign w_push  = r_inflight;

  // Outstanding entries after this cycle's pop. Because a pop implies that
  // occ >= 1, this value cannot underflow.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_avail && !flush_i && (w_level < 3'd2);

  // The returning word goes into the slot just past the surviving entries.
  // That is the head when the FIFO is empty, or when its single entry is
  // being popped now. Otherwise it is the tail.
  assign w_wr_tail = (r_occ != 2'd0) && !((r_occ == 2'd1) && w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (flush_i) begin
      // Any pop in this cycle is still seen by the consumer. The committed
      // pointer, however, jumps straight to the writer's pointer.
      r_iss_ptr  <= wr_ptr_i;
      r_rd_ptr   <= wr_ptr_i;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_iss_ptr <= r_iss_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_head   <= r_tail;
      end
      // Writing the pushed word after the pop shift lets it override the
      // shifted head when both target the head slot.
      if (w_push) begin
        if (w_wr_tail) begin
          r_tail <= mem_data_read_i;
        end else begin
          r_head <= mem_data_read_i;
        end
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign mem_addr_read_o = r_iss_ptr[ADDR_WIDTH-1:0];
  assign rd_ptr_o        = r_rd_ptr;
  assign data_o          = r_head;
  assign valid_o         = (r_occ != 2'd0);

endmodule

// File: tb/tb_mem_2ps_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_2ps_stream_reader
//
// Purpose:
//   Directed, self-checking bench for mem_2ps_stream_reader.
//   - A table of per-cycle vectors covers reset and the first
//     back-to-back burst.
//   - Hand-written sequences cover:
//       backpressure stall,
//       pointer wrap,
//       full writer,
//       flush,
//       mid-stream reset.
//
// Timing:
//   Each cycle, inputs are driven and outputs sampled 2 time units after
//   the rising edge.
//
// Memory model:
//   A behavioural memory with a 1-cycle registered read stands in for the
//   dual-port RAM. Data is written before wr_ptr_i is advanced.
// ---------------------------------------------------------------------------
module tb_mem_2ps_stream_reader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [AW:0]   wr_ptr_i;
  logic [AW:0]   rd_ptr_o;
  logic          flush_i;
  logic [AW-1:0] mem_addr_read_o;
  logic [DW-1:0] mem_data_read_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];

  int n_tests;
  int n_fail;

  mem_2ps_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_ptr_i        (wr_ptr_i),
    .rd_ptr_o        (rd_ptr_o),
    .flush_i         (flush_i),
    .mem_addr_read_o (mem_addr_read_o),
    .mem_data_read_i (mem_data_read_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory model
  always @(posedge clk) mem_data_read_i <= mem[mem_addr_read_o];

  typedef struct packed {
    logic          rst;
    logic [AW:0]   wr;
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_rd;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold ready high and pop everything in exp_q.
  // Once the stream starts it must not gap. Afterwards valid_o must drop
  // and rd_ptr_o must land on exp_rd.
  task automatic drain(input int budget, input logic [AW:0] exp_rd);
    bit            started;
    int            cyc;
    logic [DW-1:0] e;
    started = 1'b0;
    cyc     = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      tick();
      ready_i = 1'b1;
      cyc++;
      if (started) chk("stream_no_gap", {31'd0, valid_o}, 32'd1);
      if (valid_o) begin
        started = 1'b1;
        e = exp_q.pop_front();
        $display("[TB] pop data=0x%02h expected=0x%02h rd_ptr=%05b", data_o, e, rd_ptr_o);
        chk("stream_data", {24'd0, data_o}, {24'd0, e});
      end
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    tick();
    chk("drain_valid_low", {31'd0, valid_o}, 32'd0);
    chk("drain_rd_ptr", {27'd0, rd_ptr_o}, {27'd0, exp_rd});
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    wr_ptr_i = '0;
    flush_i  = 1'b0;
    ready_i  = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h11;
    mem[1] = 8'h12;
    mem[2] = 8'h13;

    // Fields:               rst   wr      rdy   v     data   rd      addr
    vecs[0] = '{1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 4'd0};
    vecs[1] = '{1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 4'd0};
    vecs[2] = '{1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 4'd0};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 5'd0, 4'd0};
    vecs[4] = '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 5'd0, 4'd0};  // burst cycle 0
    vecs[5] = '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 5'd0, 4'd1};
    vecs[6] = '{1'b0, 5'd3, 1'b1, 1'b1, 8'h11, 5'd0, 4'd2};
    vecs[7] = '{1'b0, 5'd3, 1'b1, 1'b1, 8'h12, 5'd1, 4'd3};
    vecs[8] = '{1'b0, 5'd3, 1'b1, 1'b1, 8'h13, 5'd2, 4'd3};
    vecs[9] = '{1'b0, 5'd3, 1'b1, 1'b0, 8'h00, 5'd3, 4'd3};

    repeat (2) @(posedge clk);

    // Reset and the 3-entry back-to-back burst
    for (int i = 0; i < 10; i++) begin
      tick();
      rst      = vecs[i].rst;
      wr_ptr_i = vecs[i].wr;
      ready_i  = vecs[i].ready;
      $display("[TB] vec %0d: valid=%0b data=0x%02h rd_ptr=%0d addr=%0d", i, valid_o, data_o, rd_ptr_o, mem_addr_read_o);
      chk("vec_valid", {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk("vec_data", {24'd0, data_o}, {24'd0, vecs[i].exp_data});
      chk("vec_rd_ptr", {27'd0, rd_ptr_o}, {27'd0, vecs[i].exp_rd});
      chk("vec_addr", {28'd0, mem_addr_read_o}, {28'd0, vecs[i].exp_addr});
    end

    // Backpressure: 5 entries at addr 3..7, with ready low for cycles 0-5
    for (int k = 0; k < 5; k++) mem[3+k] = 8'hA0 + 8'(k);
    tick();
    ready_i  = 1'b0;
    wr_ptr_i = 5'd8;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c >= 2) begin
        chk("stall_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_data", {24'd0, data_o}, 32'hA0);
        chk("stall_iss_ptr", {28'd0, mem_addr_read_o}, 32'd5);
        chk("stall_rd_ptr", {27'd0, rd_ptr_o}, 32'd3);
      end
    end
    for (int k = 0; k < 5; k++) exp_q.push_back(8'hA0 + 8'(k));
    drain(20, 5'd8);

    // Wrap: bring rd_ptr to 14, then read addresses 14,15,0,1
    for (int k = 0; k < 6; k++) begin
      mem[8+k] = 8'hB0 + 8'(k);
      exp_q.push_back(8'hB0 + 8'(k));
    end
    wr_ptr_i = 5'd14;
    drain(20, 5'b01110);
    mem[14] = 8'hC0;
    mem[15] = 8'hC1;
    mem[0]  = 8'hC2;
    mem[1]  = 8'hC3;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'hC0 + 8'(k));
    wr_ptr_i = 5'b10010;
    drain(20, 5'b10010);

    // Full writer: 16 entries, wr_ptr = rd_ptr with the MSB flipped
    for (int k = 0; k < 16; k++) begin
      mem[(2+k) % 16] = 8'hD0 + 8'(k);
      exp_q.push_back(8'hD0 + 8'(k));
    end
    wr_ptr_i = 5'b00010;
    drain(40, 5'b00010);

    // Flush while 1 entry is buffered and 1 read is in flight
    for (int k = 0; k < 7; k++) mem[2+k] = 8'hE0 + 8'(k);
    ready_i  = 1'b0;
    wr_ptr_i = 5'd9;
    tick();
    tick();
    chk("preflush_valid", {31'd0, valid_o}, 32'd1);
    chk("preflush_data", {24'd0, data_o}, 32'hE0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_rd_ptr", {27'd0, rd_ptr_o}, 32'd9);
    chk("flush_iss_ptr", {28'd0, mem_addr_read_o}, 32'd9);
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_no_stale", {31'd0, valid_o}, 32'd0);
    end
    mem[9]   = 8'h5A;
    wr_ptr_i = 5'd10;
    tick();
    chk("postflush_c1_valid", {31'd0, valid_o}, 32'd0);
    tick();
    chk("postflush_c2_valid", {31'd0, valid_o}, 32'd1);
    chk("postflush_c2_data", {24'd0, data_o}, 32'h5A);
    tick();
    chk("postflush_done_valid", {31'd0, valid_o}, 32'd0);
    chk("postflush_rd_ptr", {27'd0, rd_ptr_o}, 32'd10);

    // Mid-stream reset while valid_o is high and a read is in flight
    for (int k = 0; k < 3; k++) mem[10+k] = 8'hF0 + 8'(k);
    ready_i  = 1'b0;
    wr_ptr_i = 5'd13;
    tick();
    tick();
    chk("prerst_valid", {31'd0, valid_o}, 32'd1);
    chk("prerst_data", {24'd0, data_o}, 32'hF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_rd_ptr", {27'd0, rd_ptr_o}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr_read_o}, 32'd0);
    mem[0] = 8'h70;
    mem[1] = 8'h71;
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    wr_ptr_i = 5'd2;
    drain(20, 5'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
